dz_scan: RTL and testbench

DZ_SCAN -- requirements
Module: dz_scan

---
 rtl/dz_pkg.sv | 26 ++
 rtl/dz_font.sv | 17 +
 rtl/dz_scan.sv | 118 +++++++++++
 tb/tb_dz_scan.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dz_pkg.sv
// Shared definitions for the dot-matrix countdown scanner: colour states,
// blanking constant and the 8x8 glyph table.
package dz_pkg;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_RED_ON  = 2'd1,
        ST_RED_OFF = 2'd2
    } colour_e;

    localparam logic [7:0] ROW_OFF = 8'hFF;
    localparam int         DIGIT_W = 3;

    // One 64-bit word per digit, row 0 in the top byte, MSB = leftmost column.
    localparam logic [0:7][63:0] GLYPH = '{
        64'h3C666E7666663C00,
        64'h183818181818_3C00,
        64'h3C66060C30607E00,
        64'h3C66061C06663C00,
        64'h0C1C3C6C7E0C0C00,
        64'h7E607C0606663C00,
        64'h0000000000000000,
        64'h0000000000000000
    };

endpackage

// File: rtl/dz_font.sv
// Combinational glyph lookup: digit and row index to one 8-bit column pattern.
module dz_font
    import dz_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic [2:0]         row_idx,
    output logic [7:0]         glyph
);

    logic [2:0] byte_sel;

    always_comb begin
        byte_sel = 3'd7 - row_idx;
        glyph    = GLYPH[digit][{byte_sel, 3'b000} +: 8];
    end

endmodule

// File: rtl/dz_scan.sv
// 8x8 bicolour matrix scanner for a countdown digit: row multiplexing,
// frame-synchronous digit update and a green / blinking-red colour FSM.
module dz_scan
    import dz_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               digit_vld,
    input  logic               done,
    output logic [7:0]         row,
    output logic [7:0]         colr,
    output logic [7:0]         colg,
    output logic               frame_start
);

    localparam logic [9:0] PRESC_MAX  = 10'(SCAN_DIV - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [9:0]         presc_q, presc_d;
    logic [2:0]         idx_q, idx_d;
    logic [DIGIT_W-1:0] pend_q, pend_d;
    logic [DIGIT_W-1:0] act_q, act_d;
    logic [7:0]         fcnt_q, fcnt_d;
    colour_e            state_q, state_d;
    logic [7:0]         row_q, row_d;
    logic [7:0]         colr_q, colr_d;
    logic [7:0]         colg_q, colg_d;
    logic               fs_q, fs_d;

    logic       tick;
    logic       frame_end;
    logic       blink_due;
    logic [7:0] glyph;

    dz_font u_font (
        .digit   (act_q),
        .row_idx (idx_q),
        .glyph   (glyph)
    );

    always_comb begin
        tick      = (presc_q == PRESC_MAX);
        frame_end = tick && (idx_q == 3'd7);
        presc_d   = tick ? 10'd0 : presc_q + 10'd1;
        idx_d     = tick ? idx_q + 3'd1 : idx_q;
        pend_d    = digit_vld ? digit : pend_q;
        act_d     = act_q;
        // A strobe landing on the boundary bypasses the stale pending value.
        if (frame_end) begin
            act_d = digit_vld ? digit : pend_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        blink_due = (fcnt_q == BLINK_LAST);
        if (frame_end) begin
            case (state_q)
                ST_GREEN:   if (done) state_d = ST_RED_ON;
                ST_RED_ON:  if (!done) state_d = ST_GREEN;
                            else if (blink_due) state_d = ST_RED_OFF;
                ST_RED_OFF: if (!done) state_d = ST_GREEN;
                            else if (blink_due) state_d = ST_RED_ON;
                default:    state_d = ST_GREEN;
            endcase
            fcnt_d = (state_d != state_q) ? 8'd0 : fcnt_q + 8'd1;
        end
    end

    always_comb begin
        row_d  = ~(8'd1 << idx_q);
        fs_d   = (idx_q == 3'd0) && (presc_q == 10'd0);
        colr_d = 8'h00;
        colg_d = 8'h00;
        case (state_q)
            ST_GREEN:  colg_d = glyph;
            ST_RED_ON: colr_d = glyph;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= 10'd0;
            idx_q   <= 3'd0;
            pend_q  <= '0;
            act_q   <= '0;
            fcnt_q  <= 8'd0;
            state_q <= ST_GREEN;
            row_q   <= ROW_OFF;
            colr_q  <= 8'h00;
            colg_q  <= 8'h00;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
            row_q   <= row_d;
            colr_q  <= colr_d;
            colg_q  <= colg_d;
            fs_q    <= fs_d;
        end
    end

    assign row         = row_q;
    assign colr        = colr_q;
    assign colg        = colg_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_dz_scan.sv
// Directed bench for dz_scan with SCAN_DIV=1, BLINK_FRAMES=2.
module tb_dz_scan;

    logic       clk;
    logic       rst;
    logic [2:0] digit;
    logic       digit_vld;
    logic       done;
    logic [7:0] row;
    logic [7:0] colr;
    logic [7:0] colg;
    logic       frame_start;

    int checks;
    int errors;

    dz_scan #(
        .SCAN_DIV     (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit       (digit),
        .digit_vld   (digit_vld),
        .done        (done),
        .row         (row),
        .colr        (colr),
        .colg        (colg),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gl(input int d, input int r);
        logic [7:0] v;
        v = 8'h00;
        if (d == 0) begin
            case (r)
                0: v = 8'h3C; 1: v = 8'h66; 2: v = 8'h6E; 3: v = 8'h76;
                4: v = 8'h66; 5: v = 8'h66; 6: v = 8'h3C; default: v = 8'h00;
            endcase
        end else if (d == 1) begin
            case (r)
                0: v = 8'h18; 1: v = 8'h38; 6: v = 8'h3C; 7: v = 8'h00;
                default: v = 8'h18;
            endcase
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; digit = 3'd0; digit_vld = 1'b0; done = 1'b0;
        #2 rst = 1'b0;
        step(); step();
        checks++; if (row !== 8'hFF) begin errors++; $display("FAIL reset_row: got %h want ff", row); end
        checks++; if (colr !== 8'h00) begin errors++; $display("FAIL reset_colr: got %h want 00", colr); end
        checks++; if (colg !== 8'h00) begin errors++; $display("FAIL reset_colg: got %h want 00", colg); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    endtask

    task automatic test_scan();
        logic [7:0] er;
        int r;
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            r  = k % 8;
            er = ~(8'h01 << r);
            checks++; if (row !== er) begin errors++; $display("FAIL scan_row k=%0d: got %h want %h", k, row, er); end
            checks++; if (frame_start !== 1'(r == 0)) begin errors++; $display("FAIL scan_fs k=%0d: got %b want %b", k, frame_start, (r == 0)); end
            checks++; if (colg !== gl(0, r)) begin errors++; $display("FAIL scan_colg k=%0d: got %h want %h", k, colg, gl(0, r)); end
            checks++; if (colr !== 8'h00) begin errors++; $display("FAIL scan_colr k=%0d: got %h want 00", k, colr); end
        end
    endtask

    task automatic test_midframe();
        logic [7:0] er;
        repeat (4) step();
        digit = 3'd1; digit_vld = 1'b1;
        for (int r = 4; r < 8; r++) begin
            step();
            digit_vld = 1'b0;
            er = ~(8'h01 << r);
            checks++; if (row !== er) begin errors++; $display("FAIL mid_row r=%0d: got %h want %h", r, row, er); end
            checks++; if (colg !== gl(0, r)) begin errors++; $display("FAIL mid_old_colg r=%0d: got %h want %h", r, colg, gl(0, r)); end
        end
        for (int r = 0; r < 8; r++) begin
            step();
            er = ~(8'h01 << r);
            checks++; if (row !== er) begin errors++; $display("FAIL mid_new_row r=%0d: got %h want %h", r, row, er); end
            checks++; if (colg !== gl(1, r)) begin errors++; $display("FAIL mid_new_colg r=%0d: got %h want %h", r, colg, gl(1, r)); end
            checks++; if (frame_start !== 1'(r == 0)) begin errors++; $display("FAIL mid_new_fs r=%0d: got %b want %b", r, frame_start, (r == 0)); end
        end
    endtask

    task automatic test_boundary(input int d, input int prev);
        repeat (7) step();
        checks++; if (row !== 8'hBF) begin errors++; $display("FAIL bnd_sync: got %h want bf", row); end
        digit = 3'(d); digit_vld = 1'b1;
        step();
        digit_vld = 1'b0;
        checks++; if (row !== 8'h7F) begin errors++; $display("FAIL bnd_row7: got %h want 7f", row); end
        checks++; if (colg !== gl(prev, 7)) begin errors++; $display("FAIL bnd_colg7: got %h want %h", colg, gl(prev, 7)); end
        for (int r = 0; r < 8; r++) begin
            step();
            checks++; if (colg !== gl(d, r)) begin errors++; $display("FAIL bnd_colg d=%0d r=%0d: got %h want %h", d, r, colg, gl(d, r)); end
            if (r == 0) begin
                checks++; if (frame_start !== 1'b1 || row !== 8'hFE) begin errors++; $display("FAIL bnd_fe: got row %h fs %b want fe 1", row, frame_start); end
            end
        end
    endtask

    task automatic test_blink();
        int mode;
        logic [7:0] er, eg;
        step();
        done = 1'b1;
        for (int r = 1; r < 8; r++) begin
            step();
            checks++; if (colg !== gl(1, r) || colr !== 8'h00) begin errors++; $display("FAIL blink_pre r=%0d: got g=%h r=%h want g=%h r=00", r, colg, colr, gl(1, r)); end
        end
        // frames: red, red, off, off, red (done drops here), green
        for (int f = 0; f < 6; f++) begin
            mode = (f < 2) ? 1 : (f < 4) ? 2 : (f == 4) ? 1 : 0;
            for (int r = 0; r < 8; r++) begin
                step();
                er = (mode == 1) ? gl(1, r) : 8'h00;
                eg = (mode == 0) ? gl(1, r) : 8'h00;
                checks++; if (colr !== er || colg !== eg || row !== ~(8'h01 << r)) begin
                    errors++;
                    $display("FAIL blink f=%0d r=%0d: got row=%h r=%h g=%h want row=%h r=%h g=%h", f, r, row, colr, colg, ~(8'h01 << r), er, eg);
                end
                if (f == 4 && r == 3) done = 1'b0;
            end
        end
    endtask

    task automatic test_blank();
        digit = 3'd6; digit_vld = 1'b1;
        for (int r = 0; r < 8; r++) begin
            step();
            digit_vld = 1'b0;
            checks++; if (colg !== gl(1, r)) begin errors++; $display("FAIL blank_pre r=%0d: got %h want %h", r, colg, gl(1, r)); end
        end
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 8; r++) begin
                step();
                if (f == 0 && r == 0) done = 1'b1;
                checks++; if (colg !== 8'h00 || colr !== 8'h00 || row !== ~(8'h01 << r)) begin
                    errors++;
                    $display("FAIL blank f=%0d r=%0d: got row=%h r=%h g=%h want row=%h r=00 g=00", f, r, row, colr, colg, ~(8'h01 << r));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        digit = 3'd1; digit_vld = 1'b1;
        step();
        digit_vld = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (row == 8'hFE && colr == 8'h18) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL arst_wait: red frame not seen, row=%h colr=%h", row, colr); end
        repeat (4) step();
        checks++; if (row !== 8'hEF || colr !== 8'h18) begin errors++; $display("FAIL arst_pre: got row=%h colr=%h want ef 18", row, colr); end
        #1 rst = 1'b0;
        #1;
        checks++; if (row !== 8'hFF || colr !== 8'h00 || colg !== 8'h00 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL arst_now: got row=%h r=%h g=%h fs=%b want ff 00 00 0", row, colr, colg, frame_start);
        end
        step();
        done = 1'b0;
        rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step();
            checks++; if (row !== ~(8'h01 << r) || colg !== gl(0, r) || colr !== 8'h00 || frame_start !== 1'(r == 0)) begin
                errors++;
                $display("FAIL arst_after r=%0d: got row=%h r=%h g=%h fs=%b want row=%h r=00 g=%h", r, row, colr, colg, frame_start, ~(8'h01 << r), gl(0, r));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_scan();
        test_midframe();
        test_boundary(0, 1);
        test_boundary(1, 0);
        test_blink();
        test_blank();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
